// File: rtl/pn_checker_if.sv
// Bus between PN source and pn_checker: received bit stream in, lock/error status out.
interface pn_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic             in_bit;
  logic             in_valid;
  logic             locked;
  logic             bit_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_bit, in_valid,
    input  locked, bit_err, err_cnt
  );

  modport slave (
    input  in_bit, in_valid,
    output locked, bit_err, err_cnt
  );
endinterface

// File: rtl/pn_checker.sv
// Self-synchronising checker for the period-15 PN sequence x[k+4] = x[k+3] ^ x[k].
// Define PN_CHK_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is 0.
module pn_checker #(
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  pn_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] hist_q, hist_d;
  logic [2:0] fill_q, fill_d;
  logic [3:0] good_q, good_d;
  logic [3:0] miss_q, miss_d;
  logic       bit_err_q, bit_err_d;
  logic       pred;

  // hist[0] is the newest bit, hist[3] the oldest of the last four.
  assign pred = hist_q[0] ^ hist_q[3];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      bit_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      bit_err_q <= bit_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    good_d    = good_q;
    miss_d    = miss_q;
    bit_err_d = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          hist_d = {hist_q[2:0], bus.in_bit};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd3) begin
            state_d = VERIFY;
            good_d  = '0;
          end
        end
        VERIFY: begin
          hist_d = {hist_q[2:0], bus.in_bit};
          // An all-zero history predicts zeros forever, so it never earns credit.
          if ((bus.in_bit == pred) && (hist_q != '0)) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d = LOCK;
              miss_d  = '0;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCK: begin
          hist_d = {hist_q[2:0], pred};
          if (bus.in_bit == pred) begin
            miss_d = '0;
          end else begin
            bit_err_d = 1'b1;
            miss_d    = miss_q + 4'd1;
            if (miss_q + 4'd1 == 4'(MISS_MAX)) begin
              state_d = HUNT;
              fill_d  = '0;
              hist_d  = '0;
              good_d  = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.locked  = (state_q == LOCK);
  assign bus.bit_err = bit_err_q;

`ifdef PN_CHK_ERR_CNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= '0;
    end else if (bit_err_d && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = '0;
`endif

endmodule
